cordic_ci_master: RTL and testbench

Initiator side of the CORDIC custom-instruction handshake. Accepts a stream of IEEE-754 single-precision angles, buffers them in a small FIFO, and issues them one at a time to a multicycle CORDIC unit over its start/clk_en/done interface. Captures each result into a ready/valid output register. Sits between the host-side datapath and the CORDIC core, and owns the core's reset and clock-enable.

---
 rtl/cordic_ci_master.sv | 166 ++++++++++++++++
 tb/tb_cordic_ci_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_ci_master.sv
// Initiator side of the CORDIC custom-instruction handshake: angle FIFO, issue FSM and
// ready/valid result register. Optional watchdog abort enabled by `define CORDIC_CI_TIMEOUT_EN.
module cordic_ci_master #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_angle,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_err,
   output logic        ci_reset,
   output logic        ci_clk_en,
   output logic        ci_start,
   output logic [31:0] ci_dataa,
   input  logic [31:0] ci_result,
   input  logic        ci_done,
   output logic        busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
      $error("cordic_ci_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
`ifdef CORDIC_CI_TIMEOUT_EN
      ,
      S_ABORT = 2'd3
`endif
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push, pop;
   logic          load_dataa, capture, abort_cap;
   logic          ci_reset_q;
   logic [31:0]   ci_dataa_q;
   logic          out_valid_q, out_err_q;
   logic [31:0]   out_result_q;

   assign in_ready = (count_q != (AW + 1)'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state_q == S_ISSUE);

   // NOTE: the angle storage has no reset; only pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_angle;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef CORDIC_CI_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     to_cnt_q <= '0;
      else if (state_q == S_ISSUE)  to_cnt_q <= '0;
      else if (state_q == S_WAIT)   to_cnt_q <= to_cnt_q + 1'b1;
   end
`endif

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      load_dataa = 1'b0;
      capture    = 1'b0;
      abort_cap  = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Holding off while ci_reset is still high keeps the release edge free of issues.
            if (count_q != '0 && (!out_valid_q || out_ready) && !ci_reset_q) begin
               state_d    = S_ISSUE;
               load_dataa = 1'b1;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (ci_done) begin
               capture = 1'b1;
               state_d = S_IDLE;
            end
`ifdef CORDIC_CI_TIMEOUT_EN
            else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
               state_d = S_ABORT;
            end
`endif
         end
`ifdef CORDIC_CI_TIMEOUT_EN
         S_ABORT: begin
            abort_cap = 1'b1;
            state_d   = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         ci_reset_q   <= 1'b1;
         ci_dataa_q   <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_err_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ci_reset_q <= 1'b0;
         // Loaded on entry to ISSUE so the angle is on the bus alongside ci_start.
         if (load_dataa) ci_dataa_q <= mem_q[rd_ptr_q];
         if (capture) begin
            out_result_q <= ci_result;
            out_valid_q  <= 1'b1;
            out_err_q    <= 1'b0;
         end else if (abort_cap) begin
            out_result_q <= 32'h7FC0_0000;
            out_valid_q  <= 1'b1;
            out_err_q    <= 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q  <= 1'b0;
         end
      end
   end

   assign ci_start   = (state_q == S_ISSUE);
   assign ci_clk_en  = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign ci_dataa   = ci_dataa_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
`ifdef CORDIC_CI_TIMEOUT_EN
   assign ci_reset   = ci_reset_q || (state_q == S_ABORT);
   assign out_err    = out_err_q;
`else
   assign ci_reset   = ci_reset_q;
   assign out_err    = 1'b0;
`endif
   assign busy       = (state_q != S_IDLE) || (count_q != '0) || out_valid_q;

endmodule

// File: tb/tb_cordic_ci_master.sv
// Directed bench for cordic_ci_master with a behavioural CORDIC core stub.
module tb_cordic_ci_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_angle = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_err;
   logic        ci_reset, ci_clk_en, ci_start;
   logic [31:0] ci_dataa;
   logic [31:0] ci_result;
   logic        ci_done;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cordic_ci_master #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
      .ci_reset(ci_reset), .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_dataa(ci_dataa),
      .ci_result(ci_result), .ci_done(ci_done), .busy(busy)
   );

   // Core stub: ci_done pulses stub_lat cycles after the ci_start cycle.
   int          stub_cnt   = 0;
   int          stub_lat   = 20;
   bit          stub_never = 1'b0;
   bit          stub_echo  = 1'b0;
   logic [31:0] stub_res   = 32'h3F5A_E99F;
   logic [31:0] stub_data  = '0;
   logic        stub_done  = 1'b0;
   logic [31:0] stub_out   = '0;
   logic        spur_done  = 1'b0;
   logic [31:0] spur_res   = '0;

   assign ci_done   = stub_done | spur_done;
   assign ci_result = spur_done ? spur_res : stub_out;

   always @(negedge clk) begin
      stub_done = 1'b0;
      stub_out  = '0;
      if (ci_reset) begin
         stub_cnt = 0;
      end else if (stub_cnt > 0) begin
         stub_cnt = stub_cnt - 1;
         if (stub_cnt == 0) begin
            stub_done = 1'b1;
            stub_out  = stub_echo ? (stub_data ^ 32'hA5A5_A5A5) : stub_res;
         end
      end else if (ci_start && !stub_never) begin
         stub_cnt  = stub_lat;
         stub_data = ci_dataa;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_angle = a;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin
            step();
            ok = 1'b1;
            break;
         end
         step();
      end
      in_valid = 1'b0;
      if (!ok) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 300) begin
         step();
         k++;
      end
      if (!out_valid) check("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_start(output int k);
      k = 0;
      while (!ci_start && k < 300) begin
         step();
         k++;
      end
      if (!ci_start) check("wait_start_timeout", 32'd0, 32'd1);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   logic [31:0] angles [5];
   initial begin
      angles[0] = 32'h3F0B_851F;
      angles[1] = 32'h3E80_0000;
      angles[2] = 32'hBF00_0000;
      angles[3] = 32'h3FC9_0FDB;
      angles[4] = 32'h0000_0000;
   end

   initial begin
      int k;
      bit bad_start, bad_hold;
      logic [31:0] held;

      // Reset state
      #12;
      check("rst_ci_reset", 32'(ci_reset), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_ci_clk_en", 32'(ci_clk_en), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      step();
      check("rel_ci_reset", 32'(ci_reset), 32'd0);

      // Single op, 20-cycle core
      stub_lat = 20; stub_echo = 1'b0; stub_res = 32'h3F5A_E99F;
      push(32'h3F0B_851F);
      check("t1_no_start_at_N", 32'(ci_start), 32'd0);
      step();
      check("t1_start_N1", 32'(ci_start), 32'd1);
      check("t1_clk_en", 32'(ci_clk_en), 32'd1);
      check("t1_dataa", ci_dataa, 32'h3F0B_851F);
      wait_valid(k);
      check("t1_latency", 32'(k), 32'd21);
      check("t1_result", out_result, 32'h3F5A_E99F);
      check("t1_err", 32'(out_err), 32'd0);
      check("t1_dataa_hold", ci_dataa, 32'h3F0B_851F);
      handshake();
      check("t1_valid_clear", 32'(out_valid), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // Spurious done while idle
      spur_res = 32'hDEAD_BEEF; spur_done = 1'b1;
      step();
      spur_done = 1'b0;
      check("spur_valid", 32'(out_valid), 32'd0);
      check("spur_busy", 32'(busy), 32'd0);
      check("spur_result", out_result, 32'h3F5A_E99F);

      // FIFO fill, ordering and backpressure
      stub_lat = 5; stub_echo = 1'b1;
      for (int i = 0; i < 5; i++) push(angles[i]);
      check("fill_in_ready", 32'(in_ready), 32'd0);
      wait_valid(k);
      check("fill_res0", out_result, angles[0] ^ 32'hA5A5_A5A5);
      held = out_result;
      bad_start = 1'b0; bad_hold = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (ci_start) bad_start = 1'b1;
         if (out_result !== held || !out_valid) bad_hold = 1'b1;
      end
      check("bp_no_issue", 32'(bad_start), 32'd0);
      check("bp_stable", 32'(bad_hold), 32'd0);
      handshake();
      check("bp_resume_issue", 32'(ci_start), 32'd1);
      check("bp_resume_dataa", ci_dataa, angles[1]);
      step();
      check("bp_in_ready_back", 32'(in_ready), 32'd1);
      for (int i = 1; i < 5; i++) begin
         wait_valid(k);
         check($sformatf("fill_res%0d", i), out_result, angles[i] ^ 32'hA5A5_A5A5);
         handshake();
      end
      repeat (30) step();
      check("fill_no_dup", 32'(out_valid), 32'd0);
      check("fill_drained", 32'(busy), 32'd0);

      // Reset mid-WAIT
      stub_lat = 20; stub_echo = 1'b0;
      push(32'h4000_0000);
      wait_start(k);
      repeat (10) step();
      rst = 1'b0;
      #1;
      check("mrst_ci_reset", 32'(ci_reset), 32'd1);
      check("mrst_clk_en", 32'(ci_clk_en), 32'd0);
      check("mrst_dataa", ci_dataa, 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      step();
      step();
      rst = 1'b1;
      #1;
      check("mrst_hold_reset", 32'(ci_reset), 32'd1);
      step();
      check("mrst_release", 32'(ci_reset), 32'd0);
      check("mrst_no_start", 32'(ci_start), 32'd0);
      spur_res = 32'h1234_5678; spur_done = 1'b1;
      step();
      spur_done = 1'b0;
      check("mrst_late_done", 32'(out_valid), 32'd0);
      check("mrst_idle", 32'(busy), 32'd0);

`ifdef CORDIC_CI_TIMEOUT_EN
      // Timeout abort
      stub_never = 1'b1;
      push(32'h3F80_0000);
      wait_start(k);
      k = 0;
      while (!ci_reset && k < 300) begin
         step();
         k++;
      end
      check("to_abort_cycle", 32'(k), 32'd65);
      check("to_clk_en", 32'(ci_clk_en), 32'd0);
      step();
      check("to_reset_pulse", 32'(ci_reset), 32'd0);
      check("to_valid", 32'(out_valid), 32'd1);
      check("to_nan", out_result, 32'h7FC0_0000);
      check("to_err", 32'(out_err), 32'd1);
      handshake();
      // Done on the timeout cycle wins
      stub_never = 1'b0; stub_lat = 64; stub_res = 32'h3F35_04F3;
      push(32'h3F80_0000);
      wait_valid(k);
      check("to_race_result", out_result, 32'h3F35_04F3);
      check("to_race_err", 32'(out_err), 32'd0);
      handshake();
`else
      check("err_tied_low", 32'(out_err), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
